// File: rtl/flag_crossing_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : flag_crossing_scheduler
// Description : Round-robin arbiter that shares one toggle-based flag crossing
//               among NUM_CH requesters, with ack timeout and CE-gated holdoff.
// Revision    : 1.0 - initial release
// ============================================================================
module flag_crossing_scheduler #(
    parameter int  NUM_CH    = 4,
    parameter int  CNT_WIDTH = 4,
    parameter int  TIMEOUT   = 64,
    parameter int  GAP       = 3,
    localparam int CH_WIDTH  = ($clog2(NUM_CH) > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                CE,
    input  logic [NUM_CH-1:0]   REQ_FLAG,
    input  logic                ACK_IN,
    output logic                FLAG_OUT,
    output logic [CH_WIDTH-1:0] FLAG_CH,
    output logic [NUM_CH-1:0]   PENDING,
    output logic [NUM_CH-1:0]   OVERFLOW,
    output logic                TIMEOUT_ERR,
    output logic                BUSY
);

    localparam int c_tmr_width = $clog2(TIMEOUT + 1);
    localparam int c_gap_width = (GAP > 0) ? $clog2(GAP + 1) : 1;

    localparam logic [1:0] c_idle     = 2'd0;
    localparam logic [1:0] c_issue    = 2'd1;
    localparam logic [1:0] c_wait_ack = 2'd2;
    localparam logic [1:0] c_holdoff  = 2'd3;

    localparam logic [CNT_WIDTH-1:0] c_cnt_max = '1;

    logic [1:0]             r_state;
    logic [1:0]             w_state_next;
    logic [CH_WIDTH-1:0]    r_ptr;
    logic [CH_WIDTH-1:0]    r_flag_ch;
    logic [c_tmr_width-1:0] r_timer;
    logic [c_gap_width-1:0] r_gap;
    logic                   r_timeout_err;
    logic                   w_timeout_hit;

    logic [NUM_CH-1:0]      w_pending;
    logic                   w_found;
    logic [CH_WIDTH-1:0]    w_sel;
    logic                   w_grant;
    int                     w_best;
    int                     w_dist;

    // Nearest pending channel after the pointer, wrapping around.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_best  = NUM_CH;
        w_dist  = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_dist = (c - int'(r_ptr) - 1 + NUM_CH) % NUM_CH;
            if (w_pending[c] && (w_dist < w_best)) begin
                w_best  = w_dist;
                w_sel   = CH_WIDTH'(c);
                w_found = 1'b1;
            end
        end
    end

    assign w_grant = (r_state == c_idle) && w_found;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [CNT_WIDTH-1:0] r_cnt;
            logic                 r_ovf;
            logic                 w_dec;

            assign w_dec = w_grant && (w_sel == CH_WIDTH'(gi));

            // Simultaneous request and grant cancel out, even at saturation.
            always_ff @(posedge CLK) begin
                if (RESET) begin
                    r_cnt <= '0;
                    r_ovf <= 1'b0;
                end else if (REQ_FLAG[gi] && !w_dec) begin
                    if (r_cnt == c_cnt_max) begin
                        r_ovf <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end else if (!REQ_FLAG[gi] && w_dec) begin
                    r_cnt <= r_cnt - 1'b1;
                end
            end

            assign w_pending[gi] = (r_cnt != '0);
            assign OVERFLOW[gi]  = r_ovf;
        end
    endgenerate

    always_comb begin
        w_state_next  = r_state;
        w_timeout_hit = 1'b0;
        case (r_state)
            c_idle: begin
                if (w_found) begin
                    w_state_next = c_issue;
                end
            end
            c_issue: begin
                if (CE) begin
                    w_state_next = c_wait_ack;
                end
            end
            c_wait_ack: begin
                if (ACK_IN) begin
                    w_state_next = c_holdoff;
                end else if (CE && (int'(r_timer) + 1 >= TIMEOUT)) begin
                    w_state_next  = c_holdoff;
                    w_timeout_hit = 1'b1;
                end
            end
            c_holdoff: begin
                if ((GAP == 0) || (CE && (int'(r_gap) + 1 >= GAP))) begin
                    w_state_next = c_idle;
                end
            end
            default: w_state_next = c_idle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state       <= c_idle;
            r_ptr         <= CH_WIDTH'(NUM_CH - 1);
            r_flag_ch     <= '0;
            r_timer       <= '0;
            r_gap         <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_timeout_err <= w_timeout_hit;
            if (w_grant) begin
                r_ptr     <= w_sel;
                r_flag_ch <= w_sel;
            end
            if (r_state != c_wait_ack) begin
                r_timer <= '0;
            end else if (CE) begin
                r_timer <= r_timer + 1'b1;
            end
            if (r_state != c_holdoff) begin
                r_gap <= '0;
            end else if (CE) begin
                r_gap <= r_gap + 1'b1;
            end
        end
    end

    assign FLAG_OUT    = (r_state == c_issue);
    assign FLAG_CH     = r_flag_ch;
    assign PENDING     = w_pending;
    assign TIMEOUT_ERR = r_timeout_err;
    assign BUSY        = (r_state != c_idle);

endmodule
`default_nettype wire

// File: tb/tb_flag_crossing_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_flag_crossing_scheduler
// Description : Self-checking bench: vector table, directed corner sequences
//               and randomized traffic against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_flag_crossing_scheduler;

    localparam int NUM_CH    = 4;
    localparam int CNT_WIDTH = 4;
    localparam int TIMEOUT   = 64;
    localparam int GAP       = 3;
    localparam int CNT_MAX   = (1 << CNT_WIDTH) - 1;

    localparam int P_IDLE  = 0;
    localparam int P_ISSUE = 1;
    localparam int P_WAIT  = 2;
    localparam int P_HOLD  = 3;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       CE;
    logic [3:0] REQ_FLAG;
    logic       ACK_IN;
    logic       FLAG_OUT;
    logic [1:0] FLAG_CH;
    logic [3:0] PENDING;
    logic [3:0] OVERFLOW;
    logic       TIMEOUT_ERR;
    logic       BUSY;

    flag_crossing_scheduler #(
        .NUM_CH    (NUM_CH),
        .CNT_WIDTH (CNT_WIDTH),
        .TIMEOUT   (TIMEOUT),
        .GAP       (GAP)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .CE          (CE),
        .REQ_FLAG    (REQ_FLAG),
        .ACK_IN      (ACK_IN),
        .FLAG_OUT    (FLAG_OUT),
        .FLAG_CH     (FLAG_CH),
        .PENDING     (PENDING),
        .OVERFLOW    (OVERFLOW),
        .TIMEOUT_ERR (TIMEOUT_ERR),
        .BUSY        (BUSY)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_mis = 0;

    // Sampled DUT outputs of the most recent tick
    logic       s_flag, s_terr, s_busy;
    logic [1:0] s_ch;
    logic [3:0] s_pend, s_ovf;

    // Behavioural model state
    int   m_cnt [NUM_CH];
    logic [3:0] m_ovf;
    int   m_phase, m_ptr, m_ch, m_timer, m_gap;
    logic m_terr;
    logic m_chk = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
        end
    endtask

    task automatic model_step(input logic [3:0] req, input logic ce, input logic ack,
                              input logic rst);
        int g;
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) m_cnt[i] = 0;
            m_ovf = '0; m_phase = P_IDLE; m_ptr = NUM_CH - 1; m_ch = 0;
            m_timer = 0; m_gap = 0; m_terr = 1'b0;
            return;
        end
        g = -1;
        if (m_phase == P_IDLE) begin
            for (int d = 1; d <= NUM_CH; d++) begin
                if (g < 0 && m_cnt[(m_ptr + d) % NUM_CH] > 0) g = (m_ptr + d) % NUM_CH;
            end
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (req[i] && g != i) begin
                if (m_cnt[i] == CNT_MAX) m_ovf[i] = 1'b1;
                else m_cnt[i] = m_cnt[i] + 1;
            end else if (!req[i] && g == i) begin
                m_cnt[i] = m_cnt[i] - 1;
            end
        end
        m_terr = 1'b0;
        case (m_phase)
            P_IDLE:  if (g >= 0) begin m_ptr = g; m_ch = g; m_phase = P_ISSUE; end
            P_ISSUE: if (ce) begin m_phase = P_WAIT; m_timer = 0; end
            P_WAIT: begin
                if (ack) begin
                    m_phase = P_HOLD; m_gap = 0;
                end else if (ce) begin
                    m_timer++;
                    if (m_timer == TIMEOUT) begin
                        m_terr = 1'b1; m_phase = P_HOLD; m_gap = 0;
                    end
                end
            end
            default: begin
                if (GAP == 0) m_phase = P_IDLE;
                else if (ce) begin
                    m_gap++;
                    if (m_gap == GAP) m_phase = P_IDLE;
                end
            end
        endcase
    endtask

    task automatic model_compare();
        logic [12:0] act, exp;
        logic [3:0]  pend;
        for (int i = 0; i < NUM_CH; i++) pend[i] = (m_cnt[i] != 0);
        act = {s_flag, s_ch, s_pend, s_ovf, s_terr, s_busy};
        exp = {(m_phase == P_ISSUE), 2'(m_ch), pend, m_ovf, m_terr, (m_phase != P_IDLE)};
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL model t=%0t {flag,ch,pend,ovf,terr,busy}: got %b, expected %b",
                     $time, act, exp);
        end
    endtask

    // One clock: drive inputs, sample at negedge, step the model at posedge.
    task automatic tick(input logic [3:0] req, input logic ce, input logic ack, input logic rst);
        REQ_FLAG = req; CE = ce; ACK_IN = ack; RESET = rst;
        @(negedge CLK);
        s_flag = FLAG_OUT; s_ch = FLAG_CH; s_pend = PENDING; s_ovf = OVERFLOW;
        s_terr = TIMEOUT_ERR; s_busy = BUSY;
        if (m_chk) model_compare();
        @(posedge CLK);
        model_step(req, ce, ack, rst);
        #1;
    endtask

    task automatic wait_flag(input string name, output logic ok);
        ok = 1'b0;
        for (int k = 0; k < 100 && !ok; k++) begin
            tick(4'b0000, 1'b1, 1'b0, 1'b0);
            if (s_flag) ok = 1'b1;
        end
        if (!ok) begin
            n_vec++; n_mis++;
            $display("FAIL %s: FLAG_OUT got 0 for 100 cycles, expected 1", name);
        end
    endtask

    task automatic grant_ack(input string name, input logic [1:0] exp_ch);
        logic ok;
        wait_flag(name, ok);
        if (ok) chk(name, 32'(s_ch), 32'(exp_ch));
        tick(4'b0000, 1'b1, 1'b0, 1'b0);
        tick(4'b0000, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        tick(4'b0000, 1'b1, 1'b0, 1'b1);
    endtask

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       ce;
        logic       ack;
        logic       e_flag;
        logic [1:0] e_ch;
        logic [3:0] e_pend;
        logic       e_busy;
    } vec_t;

    vec_t tbl [14];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt, first_k, first_flag_k, n2, bad;
        logic [1:0] first_ch;
        logic prev_flag;

        // Single request, ack 5 cycles after ISSUE, holdoff of 3
        tbl[0]  = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0};
        tbl[1]  = '{1'b0, 4'b0001, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0};
        tbl[2]  = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0001, 1'b0};
        tbl[3]  = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd0, 4'b0000, 1'b1};
        tbl[4]  = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1};
        tbl[5]  = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1};
        tbl[6]  = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1};
        tbl[7]  = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1};
        tbl[8]  = '{1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b1};
        tbl[9]  = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1};
        tbl[10] = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1};
        tbl[11] = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1};
        tbl[12] = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0};
        tbl[13] = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0};

        REQ_FLAG = '0; CE = 1'b0; ACK_IN = 1'b0; RESET = 1'b1;
        @(posedge CLK); #1;
        do_reset();
        m_chk = 1'b1;

        for (int r = 0; r < 14; r++) begin
            tick(tbl[r].req, tbl[r].ce, tbl[r].ack, tbl[r].rst);
            chk($sformatf("tbl[%0d] {flag,ch,pend,busy}", r),
                32'({s_flag, s_ch, s_pend, s_busy}),
                32'({tbl[r].e_flag, tbl[r].e_ch, tbl[r].e_pend, tbl[r].e_busy}));
        end
        chk("tbl reset ovf/terr", 32'({s_ovf, s_terr}), 32'd0);

        // Round robin, including wrap from pointer 3 back to 0
        do_reset();
        tick(4'b1111, 1'b1, 1'b0, 1'b0);
        grant_ack("rr_a0", 2'd0);
        grant_ack("rr_a1", 2'd1);
        grant_ack("rr_a2", 2'd2);
        grant_ack("rr_a3", 2'd3);
        tick(4'b1001, 1'b1, 1'b0, 1'b0);
        grant_ack("rr_b0", 2'd0);
        grant_ack("rr_b3", 2'd3);
        tick(4'b1001, 1'b1, 1'b0, 1'b0);
        grant_ack("rr_c0", 2'd0);
        grant_ack("rr_c3", 2'd3);

        // CE one cycle in four while in ISSUE
        do_reset();
        tick(4'b0001, 1'b1, 1'b0, 1'b0);
        tick(4'b0000, 1'b1, 1'b0, 1'b0);
        cnt = 0;
        for (int k = 0; k < 12; k++) begin
            tick(4'b0000, (k % 4 == 3), 1'b0, 1'b0);
            if (k < 4) chk($sformatf("ce_hold k=%0d FLAG_OUT", k), 32'(s_flag), 32'd1);
            if (CE && s_flag) cnt++;
        end
        chk("ce_single_sample", 32'(cnt), 32'd1);

        // Timeout then grant of the next pending channel
        do_reset();
        tick(4'b0011, 1'b1, 1'b0, 1'b0);
        tick(4'b0000, 1'b1, 1'b0, 1'b0);
        tick(4'b0000, 1'b1, 1'b0, 1'b0);
        cnt = 0; first_k = -1; first_flag_k = -1; first_ch = 2'd0;
        for (int k = 0; k < 72; k++) begin
            tick(4'b0000, 1'b1, 1'b0, 1'b0);
            if (s_terr) begin cnt++; if (first_k < 0) first_k = k; end
            if (s_flag && first_flag_k < 0) begin first_flag_k = k; first_ch = s_ch; end
        end
        chk("to_pulse_count", 32'(cnt), 32'd1);
        chk("to_pulse_cycle", 32'(first_k), 32'd64);
        chk("to_next_issue_cycle", 32'(first_flag_k), 32'd68);
        chk("to_next_issue_ch", 32'(first_ch), 32'd1);

        // Saturation of channel 2
        do_reset();
        tick(4'b0001, 1'b1, 1'b0, 1'b0);
        tick(4'b0000, 1'b1, 1'b0, 1'b0);
        tick(4'b0000, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 17; k++) tick(4'b0100, 1'b1, 1'b0, 1'b0);
        tick(4'b0000, 1'b1, 1'b1, 1'b0);
        chk("sat_pending", 32'(s_pend), 32'b0100);
        chk("sat_overflow", 32'(s_ovf), 32'b0100);
        n2 = 0; prev_flag = 1'b0;
        for (int k = 0; k < 200; k++) begin
            tick(4'b0000, 1'b1, prev_flag, 1'b0);
            if (s_flag && s_ch == 2'd2) n2++;
            prev_flag = s_flag;
        end
        chk("sat_grants_ch2", 32'(n2), 32'd15);
        chk("sat_pending_end", 32'(s_pend), 32'd0);
        chk("sat_overflow_sticky", 32'(s_ovf), 32'b0100);

        // Reset during WAIT_ACK
        do_reset();
        tick(4'b0111, 1'b1, 1'b0, 1'b0);
        tick(4'b0000, 1'b1, 1'b0, 1'b0);
        tick(4'b0000, 1'b1, 1'b0, 1'b0);
        tick(4'b0000, 1'b1, 1'b0, 1'b0);
        tick(4'b0000, 1'b1, 1'b0, 1'b1);
        tick(4'b0000, 1'b1, 1'b1, 1'b0);
        chk("rst_mid outputs", 32'({s_flag, s_ch, s_pend, s_ovf, s_terr, s_busy}), 32'd0);
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            tick(4'b0000, 1'b1, 1'b0, 1'b0);
            if (s_flag || s_terr || s_busy) bad++;
        end
        chk("rst_mid quiet cycles", 32'(bad), 32'd0);

        // Request coinciding with grant; ack on the timeout boundary
        do_reset();
        tick(4'b0010, 1'b1, 1'b0, 1'b0);
        tick(4'b0010, 1'b1, 1'b0, 1'b0);
        tick(4'b0000, 1'b1, 1'b0, 1'b0);
        chk("sim_issue {flag,ch}", 32'({s_flag, s_ch}), 32'b101);
        chk("sim_pending", 32'(s_pend), 32'b0010);
        for (int k = 0; k < 63; k++) tick(4'b0000, 1'b1, 1'b0, 1'b0);
        tick(4'b0000, 1'b1, 1'b1, 1'b0);
        cnt = 0;
        for (int k = 0; k < 5; k++) begin
            tick(4'b0000, 1'b1, 1'b0, 1'b0);
            if (s_terr) cnt++;
            if (k == 0) chk("sim_ack_boundary busy", 32'(s_busy), 32'd1);
        end
        chk("sim_ack_boundary terr", 32'(cnt), 32'd0);

        // Randomized traffic against the model
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            logic [3:0] rq;
            for (int i = 0; i < NUM_CH; i++) rq[i] = ($urandom_range(0, 5) == 0);
            tick(rq, ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 499) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/flag_crossing_scheduler.md
Name: flag_crossing_scheduler

Overview:
- Shares one toggle-based flag domain-crossing channel among NUM_CH requesters in a single clock domain.
- Counts pending single-cycle flags per requester and grants them round-robin.
- Drives the crossing's flag input and channel ID so the flag is sampled in exactly one CE-high cycle.
- Waits for a returned acknowledge, with a timeout, then enforces a minimum CE-qualified gap so back-to-back toggles are never lost at the far side.

Parameters:
- NUM_CH, 4: number of requesters, 2..16.
- CNT_WIDTH, 4: width of each per-channel pending counter; saturates at 2^CNT_WIDTH-1.
- TIMEOUT, 64: CE-qualified cycles to wait for ACK_IN before abandoning; must be >= 1.
- GAP, 3: CE-qualified holdoff cycles after ack or timeout; 0 is allowed.
- Localparam CH_WIDTH = max(1, clog2(NUM_CH)).

Ports:
- CLK  input  1  clock for the whole block.
- RESET  input  1  synchronous, active-high reset.
- CE  input  1  clock enable of the crossing's source side; the crossing samples FLAG_OUT only when CE=1.
- REQ_FLAG  input  NUM_CH  one-cycle request pulse per channel, sampled every CLK edge (not CE-gated).
- ACK_IN  input  1  one-cycle acknowledge pulse, already synchronized into CLK.
- FLAG_OUT  output  1  flag to the crossing.
- FLAG_CH  output  CH_WIDTH  channel ID of the current or most recent grant.
- PENDING  output  NUM_CH  bit i = (counter i != 0).
- OVERFLOW  output  NUM_CH  sticky: a request arrived while counter i was saturated.
- TIMEOUT_ERR  output  1  one-cycle pulse when WAIT_ACK times out.
- BUSY  output  1  high whenever state != IDLE.

Behaviour:
- Reset (synchronous, takes priority over everything, including mid-transaction):
  - All counters 0, OVERFLOW 0, FLAG_OUT 0, FLAG_CH 0, TIMEOUT_ERR 0, BUSY 0.
  - State IDLE; round-robin pointer NUM_CH-1, so channel 0 has first priority.
  - Any in-flight grant is abandoned with no error pulse.
- Counters:
  - REQ_FLAG[i]=1 increments counter i.
  - A grant to channel i decrements counter i.
  - Increment and decrement in the same cycle: counter unchanged.
  - Increment at saturation: request dropped and OVERFLOW[i] set. OVERFLOW clears only on RESET.
- FSM states: IDLE, ISSUE, WAIT_ACK, HOLDOFF.
  - IDLE: if any counter != 0, pick the first nonzero channel searching from pointer+1 with wrap-around. Then set FLAG_CH, set pointer, decrement that counter, and go to ISSUE. CE is not required for this step.
  - ISSUE: FLAG_OUT=1, combinational on state. On a CE=1 cycle, go to WAIT_ACK and clear the timer. The flag is therefore seen in exactly one CE-high cycle; FLAG_OUT may stay high across CE-low cycles.
  - WAIT_ACK: the timer increments on CE=1 cycles.
    - ACK_IN=1 goes to HOLDOFF.
    - Timer reaching TIMEOUT goes to HOLDOFF with TIMEOUT_ERR=1 for that one registered cycle. The flag is not reissued.
    - ACK_IN in the same cycle as timeout: the ack wins and there is no error.
    - ACK_IN in IDLE, ISSUE or HOLDOFF is ignored.
  - HOLDOFF: count GAP CE=1 cycles, then go to IDLE. With GAP=0, go to IDLE on the next CLK.
- Latency, with the block idle and CE=1 throughout: REQ_FLAG at cycle t → counter nonzero at t+1 → ISSUE (FLAG_OUT=1) at t+2 → WAIT_ACK at t+3.
- New requests during a transaction only accumulate in the counters; they never pre-empt the current grant.
- FLAG_CH is stable from ISSUE entry until the next grant.
- TIMEOUT_ERR is registered and is 0 in every other cycle.

Test Plan:
- Single request: RESET, CE=1, REQ_FLAG=0001 at t0, ACK_IN 5 cycles after ISSUE → FLAG_OUT high only at t0+2, FLAG_CH=0, BUSY high until GAP=3 cycles after the ack, PENDING=0000 at the end.
- Round robin: REQ_FLAG=1111 in one cycle, each grant acked 2 cycles later → grant order is channels 0,1,2,3; then REQ_FLAG=1001 gives order 0,3; then a further REQ_FLAG=1001 gives 0,3 again, because the pointer sits on 3 and the search wraps to 0.
- CE throttling: CE high one cycle in four while in ISSUE → FLAG_OUT stays high until the first CE=1 cycle, and exactly one CE-high cycle carries FLAG_OUT=1.
- Timeout: no ACK_IN after a grant, CE=1 → TIMEOUT_ERR pulses exactly once, 64 cycles after WAIT_ACK entry; the next pending channel is granted after holdoff, with no reissue of the timed-out flag.
- Saturation: 17 pulses on REQ_FLAG[2] while busy with CNT_WIDTH=4 → counter 15, OVERFLOW=0100; afterwards exactly 15 grants to channel 2.
- Reset mid-flight: assert RESET during WAIT_ACK with counters nonzero → next cycle all outputs 0, state IDLE; ACK_IN one cycle later produces no grant and no error.
- Simultaneous events: REQ_FLAG[1] in the same cycle as the IDLE grant of channel 1 with counter=1 → counter stays 1. ACK_IN in the same cycle as the timeout boundary → no TIMEOUT_ERR.
